// File: rtl/async_serial_pkg.sv
// Shared definitions for the asynchronous serial blocks: bit-period table,
// mode-to-reload helper and transmitter state encodings.
package async_serial_pkg;

  typedef enum logic [1:0] {
    MODE_2  = 2'd0,
    MODE_4  = 2'd1,
    MODE_8  = 2'd2,
    MODE_16 = 2'd3
  } sampling_mode_e;

  localparam int unsigned PERIOD_2  = 2;
  localparam int unsigned PERIOD_4  = 4;
  localparam int unsigned PERIOD_8  = 8;
  localparam int unsigned PERIOD_16 = 16;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  // Counters count PERIOD-1 down to 0, so the reload value is one less than the period.
  function automatic logic [3:0] mode_reload(input logic [1:0] mode);
    case (mode)
      2'd0:    return 4'(PERIOD_2 - 1);
      2'd1:    return 4'(PERIOD_4 - 1);
      2'd2:    return 4'(PERIOD_8 - 1);
      default: return 4'(PERIOD_16 - 1);
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Parallel-side bundle of the serial transmitter plus its serial output and
// a debug view of the FSM state.
interface uart_tx_if #(
  parameter int DATA_BITS = 8
);
  import async_serial_pkg::*;

  logic                 en;
  logic                 sampling_mode_ld;
  logic [1:0]           sampling_mode;
  logic [DATA_BITS-1:0] tx_pi;
  logic                 tx_start;
  logic                 tx_so;
  logic                 tx_busy;
  logic                 tx_done;
  tx_state_e            state;

  // Handshake: tx_start is a level request, sampled only in IDLE with en=1;
  // acceptance shows as tx_busy rising on that same edge, tx_pi is captured
  // there and ignored afterwards; tx_done pulses one cycle as tx_busy falls.
  modport master (
    output en, sampling_mode_ld, sampling_mode, tx_pi, tx_start,
    input  tx_so, tx_busy, tx_done, state
  );

  modport slave (
    input  en, sampling_mode_ld, sampling_mode, tx_pi, tx_start,
    output tx_so, tx_busy, tx_done, state
  );

endinterface

// File: rtl/uart_tx_baud.sv
// Bit-period counter for the transmitter: holds the mode register and flags
// the last clock of each bit period.
module uart_tx_baud
  import async_serial_pkg::*;
#(
  parameter logic [1:0] DEFAULT_MODE = 2'h3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  input  logic       i_mode_ld,
  input  logic [1:0] i_mode,
  input  logic       i_load,
  input  logic       i_run,
  output logic       o_tick
);

  logic [1:0] r_mode;
  logic [3:0] r_cnt;
  logic [3:0] w_reload;

  assign w_reload = mode_reload(r_mode);

  // The mode register is only read at reload time, so a change made while
  // frozen lets the bit in flight finish with its old count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= DEFAULT_MODE;
      r_cnt  <= 4'd0;
    end else if (!i_en) begin
      if (i_mode_ld) r_mode <= i_mode;
    end else if (i_load || (i_run && (r_cnt == 4'd0))) begin
      r_cnt <= w_reload;
    end else if (i_run) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign o_tick = i_run && (r_cnt == 4'd0);

endmodule

// File: rtl/uart_tx.sv
// Serial transmitter: start bit, DATA_BITS data bits MSB-first, stop bit.
// Define UART_TX_TWO_STOP_EN to send two stop bits per frame.
module uart_tx
  import async_serial_pkg::*;
#(
  parameter int         DATA_BITS    = 8,
  parameter logic [1:0] DEFAULT_MODE = 2'h3
) (
  input logic       clk,
  input logic       rst_n,
  uart_tx_if.slave  bus
);

`ifdef UART_TX_TWO_STOP_EN
  localparam logic [3:0] STOP_EXTRA = 4'd1;
`else
  localparam logic [3:0] STOP_EXTRA = 4'd0;
`endif

  tx_state_e            r_state, w_state_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic [3:0]           r_bit_cnt, w_bit_cnt_nxt;
  logic                 r_so, w_so_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 r_done, w_done_nxt;
  logic                 w_tick;
  logic                 w_accept;
  logic                 w_run;

  assign w_accept = bus.en && (r_state == TX_IDLE) && bus.tx_start;
  assign w_run    = (r_state != TX_IDLE);

  uart_tx_baud #(
    .DEFAULT_MODE (DEFAULT_MODE)
  ) u_baud (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_en      (bus.en),
    .i_mode_ld (bus.sampling_mode_ld),
    .i_mode    (bus.sampling_mode),
    .i_load    (w_accept),
    .i_run     (w_run),
    .o_tick    (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= TX_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.en) begin
      case (r_state)
        TX_IDLE:  if (bus.tx_start)                      w_state_nxt = TX_START;
        TX_START: if (w_tick)                            w_state_nxt = TX_DATA;
        TX_DATA:  if (w_tick && (r_bit_cnt == 4'd1))     w_state_nxt = TX_STOP;
        TX_STOP:  if (w_tick && (r_bit_cnt == 4'd0))     w_state_nxt = TX_IDLE;
      endcase
    end
  end

  // Next values of the registered outputs and shift path; everything holds while en=0.
  always_comb begin
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_so_nxt      = r_so;
    w_busy_nxt    = r_busy;
    w_done_nxt    = r_done;
    if (bus.en) begin
      w_done_nxt = 1'b0;
      case (r_state)
        TX_IDLE: begin
          w_so_nxt   = 1'b1;
          w_busy_nxt = 1'b0;
          if (bus.tx_start) begin
            w_shift_nxt   = bus.tx_pi;
            w_bit_cnt_nxt = 4'(DATA_BITS);
            w_so_nxt      = 1'b0;
            w_busy_nxt    = 1'b1;
          end
        end
        TX_START: begin
          if (w_tick) w_so_nxt = r_shift[DATA_BITS-1];
        end
        TX_DATA: begin
          if (w_tick) begin
            w_shift_nxt = r_shift << 1;
            if (r_bit_cnt == 4'd1) begin
              w_so_nxt      = 1'b1;
              w_bit_cnt_nxt = STOP_EXTRA;
            end else begin
              w_so_nxt      = r_shift[DATA_BITS-2];
              w_bit_cnt_nxt = r_bit_cnt - 4'd1;
            end
          end
        end
        TX_STOP: begin
          w_so_nxt = 1'b1;
          if (w_tick) begin
            if (r_bit_cnt != 4'd0) begin
              w_bit_cnt_nxt = r_bit_cnt - 4'd1;
            end else begin
              w_busy_nxt = 1'b0;
              w_done_nxt = 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_bit_cnt <= 4'd0;
      r_so      <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_so      <= w_so_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign bus.tx_so   = r_so;
  assign bus.tx_busy = r_busy;
  assign bus.tx_done = r_done;
  assign bus.state   = r_state;

endmodule
